tap_period_ctrl: RTL and testbench

TAP_PERIOD_CTRL -- requirements
Module: tap_period_ctrl

---
 rtl/tap_pkg.sv | 13 +
 rtl/tap_avg4.sv | 40 ++++
 rtl/tap_period_ctrl.sv | 159 +++++++++++++++
 tb/tb_tap_period_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// Shared definitions for the tap-tempo period controller.
//   tap_state_e : measurement FSM states
//   TAP_PER_W   : default period/counter width in timepulse units
package tap_pkg;

  localparam int unsigned TAP_PER_W = 16;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,  // no reference tap yet
    S_COUNT = 1'b1   // interval counter running since the last reference tap
  } tap_state_e;

endpackage

// File: rtl/tap_avg4.sv
// Four-entry moving average of captured tap periods.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : fill all four history entries with din_i
//   push_i       : shift din_i into the history (ignored when load_i is high)
//   din_i        : newly captured period
//   avg_o        : (sum of the four entries) >> 2, truncated to PER_W bits
module tap_avg4
  import tap_pkg::*;
#(
  parameter int unsigned PER_W = TAP_PER_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             push_i,
  input  logic [PER_W-1:0] din_i,
  output logic [PER_W-1:0] avg_o
);

  logic [PER_W-1:0] hist_q [4];
  logic [PER_W+1:0] sum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else if (load_i) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= din_i;
    end else if (push_i) begin
      hist_q[0] <= din_i;
      for (int i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  // Two guard bits keep the four-way sum exact before the divide by four.
  always_comb begin
    sum = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
    avg_o = sum[PER_W+1:2];
  end

endmodule

// File: rtl/tap_period_ctrl.sv
// Tap-tempo period controller: measures the interval between button taps in
// timepulse units and hands it to a consumer through a valid/ready handshake.
// Optional build macro TAP_PERIOD_AVG_EN reports a 4-sample moving average
// instead of the raw interval.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   tp_i           : one-cycle timepulse strobe (counting time base)
//   btn_i          : debounced button level, synchronous to clk_i
//   period_o       : measured (or averaged) interval
//   period_valid_o : period_o holds an unconsumed result
//   period_ready_i : consumer accepts period_o when high with period_valid_o
//   timeout_o      : one-cycle pulse when a measurement reaches MAX_PERIOD
//   overrun_o      : one-cycle pulse when an unconsumed result is overwritten
module tap_period_ctrl
  import tap_pkg::*;
#(
  parameter int unsigned PER_W      = TAP_PER_W,
  parameter int unsigned MIN_PERIOD = 16,
  parameter int unsigned MAX_PERIOD = 65535
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tp_i,
  input  logic             btn_i,
  output logic [PER_W-1:0] period_o,
  output logic             period_valid_o,
  input  logic             period_ready_i,
  output logic             timeout_o,
  output logic             overrun_o
);

  localparam logic [PER_W-1:0] MinCount  = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0] LastCount = PER_W'(MAX_PERIOD - 1);

  tap_state_e       state_q, state_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             tap;
  logic             capture;
  logic             timeout_d;
  logic             timeout_q;
  logic             overrun_q;
  logic             valid_q;

  // A tap is the first cycle btn_i is seen high.
  assign tap = btn_i & ~btn_q;

  // State register plus counter and button history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_i;
    end
  end

  // Next-state logic. A tap outranks the timeout timepulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (tap) state_d = S_COUNT;
      S_COUNT: if (!tap && tp_i && (cnt_q == LastCount)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic. A tap always swallows a coincident timepulse, and a
  // too-short tap leaves the running count untouched.
  always_comb begin
    cnt_d     = cnt_q;
    capture   = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tap) cnt_d = '0;
      end
      S_COUNT: begin
        if (tap) begin
          if (cnt_q >= MinCount) begin
            capture = 1'b1;
            cnt_d   = '0;
          end
        end else if (tp_i) begin
          if (cnt_q == LastCount) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Result handshake. A capture coinciding with acceptance is not an overrun.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      overrun_q <= capture & valid_q & ~period_ready_i;
      if (capture) begin
        valid_q <= 1'b1;
      end else if (valid_q && period_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef TAP_PERIOD_AVG_EN
  // Set on the reference tap that leaves S_IDLE so the next capture seeds
  // the whole history instead of averaging against stale entries.
  logic first_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      first_q <= 1'b0;
    end else if ((state_q == S_IDLE) && tap) begin
      first_q <= 1'b1;
    end else if (capture) begin
      first_q <= 1'b0;
    end
  end

  tap_avg4 #(
    .PER_W (PER_W)
  ) u_avg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (capture & first_q),
    .push_i (capture),
    .din_i  (cnt_q),
    .avg_o  (period_o)
  );
`else
  logic [PER_W-1:0] period_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      period_q <= '0;
    end else if (capture) begin
      period_q <= cnt_q;
    end
  end

  assign period_o = period_q;
`endif

  assign period_valid_o = valid_q;
  assign timeout_o      = timeout_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_tap_period_ctrl.sv
// Directed bench for tap_period_ctrl (MIN_PERIOD=4, MAX_PERIOD=100).
module tb_tap_period_ctrl;
  import tap_pkg::*;

`ifdef TAP_PERIOD_AVG_EN
  localparam bit Avg = 1'b1;
`else
  localparam bit Avg = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tp = 1'b0;
  logic        btn = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] period;
  logic        valid;
  logic        timeout;
  logic        overrun;

  int n_checks = 0;
  int n_err = 0;

  // Event counters kept by the monitor; tests work on deltas from a mark.
  int acc_cnt = 0;
  int to_cnt = 0;
  int ov_cnt = 0;
  int last_acc = 0;
  int acc_base, to_base, ov_base;

  tap_period_ctrl #(
    .PER_W      (16),
    .MIN_PERIOD (4),
    .MAX_PERIOD (100)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tp_i           (tp),
    .btn_i          (btn),
    .period_o       (period),
    .period_valid_o (valid),
    .period_ready_i (ready),
    .timeout_o      (timeout),
    .overrun_o      (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) begin
        acc_cnt  <= acc_cnt + 1;
        last_acc <= int'(period);
      end
      if (timeout) to_cnt <= to_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tp = 1'b1;
      tick();
    end
    tp = 1'b0;
  endtask

  // One tap cycle (optionally with a coincident timepulse), then one idle cycle.
  task automatic tap(input logic with_tp);
    btn = 1'b1;
    tp  = with_tp;
    tick();
    btn = 1'b0;
    tp  = 1'b0;
    tick();
  endtask

  task automatic mark();
    acc_base = acc_cnt;
    to_base  = to_cnt;
    ov_base  = ov_cnt;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    btn   = 1'b0;
    tp    = 1'b0;
    ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    mark();
  endtask

  initial begin
    // Reset state, then idle timepulses must produce nothing.
    tick();
    tick();
    check("rst_period", int'(period), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_flags", int'({timeout, overrun}), 0);
    rst = 1'b0;
    tick();
    mark();
    pulses(100);
    tick();
    check("idle_period", int'(period), 0);
    check("idle_valid", int'(valid), 0);
    check("idle_events", (acc_cnt - acc_base) + (to_cnt - to_base) + (ov_cnt - ov_base), 0);

    // Basic measurement with ready held high, plus a too-short tap.
    do_reset();
    ready = 1'b1;
    tap(1'b0);
    pulses(50);
    tap(1'b0);
    check("t50_acc1", acc_cnt - acc_base, 1);
    check("t50_val1", last_acc, 50);
    pulses(50);
    tap(1'b0);
    check("t50_acc2", acc_cnt - acc_base, 2);
    pulses(2);
    tap(1'b0);
    check("short_ignored", acc_cnt - acc_base, 2);
    pulses(48);
    tap(1'b0);
    check("t50_acc3", acc_cnt - acc_base, 3);
    check("t50_val3", last_acc, 50);
    check("t50_valid_clr", int'(valid), 0);

    // Timeout after MAX_PERIOD timepulses, continuing from the last capture.
    mark();
    pulses(100);
    tick();
    check("to_pulse", to_cnt - to_base, 1);
    check("to_state", int'(dut.state_q == S_IDLE), 1);
    tap(1'b0);
    pulses(5);
    tick();
    check("to_no_result", acc_cnt - acc_base, 0);
    check("to_single", to_cnt - to_base, 1);

    // Overrun with the consumer stalled.
    do_reset();
    tap(1'b0);
    pulses(30);
    tap(1'b0);
    pulses(40);
    tap(1'b0);
    check("ovr_period", int'(period), Avg ? 32 : 40);
    check("ovr_valid", int'(valid), 1);
    check("ovr_pulse", ov_cnt - ov_base, 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    check("ovr_valid_clr", int'(valid), 0);
    check("ovr_acc", last_acc, Avg ? 32 : 40);

    // Tap coinciding with a timepulse: that timepulse is not counted.
    do_reset();
    ready = 1'b1;
    tap(1'b0);
    pulses(20);
    tap(1'b1);
    check("tie_tp_val", last_acc, 20);

    // Capture coinciding with acceptance: no overrun, both values delivered.
    do_reset();
    tap(1'b0);
    pulses(10);
    tap(1'b0);
    pulses(20);
    ready = 1'b1;
    tap(1'b0);
    tick();
    check("cap_acc_ov", ov_cnt - ov_base, 0);
    check("cap_acc_cnt", acc_cnt - acc_base, 2);
    check("cap_acc_val", last_acc, Avg ? 12 : 20);

    // Tap on the timeout timepulse wins over the timeout.
    do_reset();
    ready = 1'b1;
    tap(1'b0);
    pulses(99);
    tap(1'b1);
    tick();
    check("tie_to_val", last_acc, 99);
    check("tie_to_none", to_cnt - to_base, 0);

    // Reset with a pending result and btn held high across release.
    do_reset();
    tap(1'b0);
    pulses(30);
    tap(1'b0);
    pulses(10);
    btn = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_period", int'(period), 0);
    rst = 1'b0;
    tick();
    btn = 1'b0;
    pulses(25);
    tap(1'b0);
    check("rel_tap_period", int'(period), 25);
    check("rel_tap_valid", int'(valid), 1);

    // Moving-average sequence (raw intervals in the default build).
    do_reset();
    ready = 1'b1;
    tap(1'b0);
    pulses(40);
    tap(1'b0);
    check("avg_1", last_acc, 40);
    pulses(40);
    tap(1'b0);
    check("avg_2", last_acc, 40);
    pulses(40);
    tap(1'b0);
    check("avg_3", last_acc, 40);
    pulses(80);
    tap(1'b0);
    check("avg_4", last_acc, Avg ? 50 : 80);
    pulses(100);
    tick();
    check("avg_to", to_cnt - to_base, 1);
    tap(1'b0);
    pulses(60);
    tap(1'b0);
    check("avg_refill", last_acc, 60);
    check("avg_acc_cnt", acc_cnt - acc_base, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
